// File: rtl/sd_block_streamer_if.sv
// rtl/sd_block_streamer_if.sv - register bus, FIFO port and sample stream of the block streamer
// Signal prefixes are from the streamer's point of view (i_ into it, o_ out of it).
interface sd_block_streamer_if;
  logic        i_start;
  logic [31:0] i_block_addr;
  logic        o_busy;
  logic        o_done;
  logic        o_error;
  logic [6:0]  o_sd_addr;
  logic        o_sd_we;
  logic [7:0]  o_sd_data;
  logic [7:0]  i_sd_data;
  logic        o_sd_fifo_rd;
  logic [7:0]  i_sd_fifo_data;
  logic [15:0] o_smp_data;
  logic        o_smp_valid;
  logic        i_smp_ready;

  modport master (
    input  i_start, i_block_addr, i_sd_data, i_sd_fifo_data, i_smp_ready,
    output o_busy, o_done, o_error, o_sd_addr, o_sd_we, o_sd_data,
           o_sd_fifo_rd, o_smp_data, o_smp_valid
  );

  modport slave (
    output i_start, i_block_addr, i_sd_data, i_sd_fifo_data, i_smp_ready,
    input  o_busy, o_done, o_error, o_sd_addr, o_sd_we, o_sd_data,
           o_sd_fifo_rd, o_smp_data, o_smp_valid
  );
endinterface

// File: rtl/sd_block_streamer.sv
// rtl/sd_block_streamer.sv - CMD17 single-block reader streaming 16-bit PCM samples
// Define SD_BYTE_ADDR_EN for byte-addressed (standard capacity) cards.
module sd_block_streamer #(
  parameter logic [6:0] STATUS_ADDR    = 7'h30,
  parameter int         DONE_BIT       = 0,
  parameter int         ERR_BIT        = 15,
  parameter logic [7:0] CMD_SETTING    = 8'b0011_1101,
  parameter int         TIMEOUT_CYCLES = 2000000
) (
  input logic                  clk,
  input logic                  rst,
  sd_block_streamer_if.master  bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_POLL, S_DRAIN, S_DONE, S_ERR
  } state_t;

  typedef enum logic [1:0] {
    P_REQ, P_LO, P_HI, P_CLR
  } poll_t;

  state_t         r_state;
  state_t         w_next;
  poll_t          r_poll;
  logic [2:0]     r_cmd_idx;
  logic [7:0]     r_stat_lo;
  logic [TW-1:0]  r_tmo;
  logic [31:0]    r_arg;
  logic [9:0]     r_pop_cnt;
  logic           r_inflight;
  logic           r_half;
  logic [7:0]     r_lo_byte;
  logic [15:0]    r_buf [2];
  logic           r_wptr;
  logic           r_rptr;
  logic [1:0]     r_cnt;
  logic [8:0]     r_smp_cnt;

  logic           w_busy;
  logic           w_start_ok;
  logic [15:0]    w_status;
  logic           w_timeout;
  logic           w_xfer;
  logic           w_push;
  logic           w_pop;
  logic [3:0]     w_occ;
  logic [31:0]    w_arg;

`ifdef SD_BYTE_ADDR_EN
  assign w_arg = {bus.i_block_addr[22:0], 9'b0};
`else
  assign w_arg = bus.i_block_addr;
`endif

  assign w_busy      = (r_state == S_CMD) || (r_state == S_POLL) || (r_state == S_DRAIN);
  assign w_start_ok  = bus.i_start && !w_busy;
  assign w_status    = {bus.i_sd_data, r_stat_lo};
  assign w_timeout   = (r_tmo == TW'(TIMEOUT_CYCLES - 1));

  assign bus.o_busy      = w_busy;
  assign bus.o_smp_valid = (r_cnt != 2'd0);
  assign bus.o_smp_data  = r_buf[r_rptr];

  assign w_xfer = bus.o_smp_valid && bus.i_smp_ready;
  assign w_push = r_inflight && r_half;

  // Byte credits committed to the 2-sample buffer; a sample leaving this cycle frees two.
  assign w_occ = {1'b0, r_cnt, 1'b0} + {3'b0, r_half} + {3'b0, r_inflight};
  assign w_pop = (r_state == S_DRAIN) && (r_pop_cnt != 10'd512) &&
                 (w_xfer ? (w_occ <= 4'd5) : (w_occ <= 4'd3));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next           = r_state;
    bus.o_done       = 1'b0;
    bus.o_error      = 1'b0;
    bus.o_sd_addr    = 7'h00;
    bus.o_sd_we      = 1'b0;
    bus.o_sd_data    = 8'h00;
    bus.o_sd_fifo_rd = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        bus.o_done  = (r_state == S_DONE);
        bus.o_error = (r_state == S_ERR);
        w_next      = w_start_ok ? S_CMD : S_IDLE;
      end
      S_CMD: begin
        bus.o_sd_we = 1'b1;
        case (r_cmd_idx)
          3'd0: begin bus.o_sd_addr = 7'h44; bus.o_sd_data = 8'hFF;         end
          3'd1: begin bus.o_sd_addr = 7'h45; bus.o_sd_data = 8'h01;         end
          3'd2: begin bus.o_sd_addr = 7'h05; bus.o_sd_data = 8'd17;         end
          3'd3: begin bus.o_sd_addr = 7'h04; bus.o_sd_data = CMD_SETTING;   end
          3'd4: begin bus.o_sd_addr = 7'h03; bus.o_sd_data = r_arg[31:24];  end
          3'd5: begin bus.o_sd_addr = 7'h02; bus.o_sd_data = r_arg[23:16];  end
          3'd6: begin bus.o_sd_addr = 7'h01; bus.o_sd_data = r_arg[15:8];   end
          default: begin bus.o_sd_addr = 7'h00; bus.o_sd_data = r_arg[7:0]; end
        endcase
        if (r_cmd_idx == 3'd7) begin
          w_next = S_POLL;
        end
      end
      S_POLL: begin
        // P_HI re-presents the low address so reads pipeline in a 2-cycle loop.
        case (r_poll)
          P_REQ: bus.o_sd_addr = STATUS_ADDR;
          P_LO:  bus.o_sd_addr = STATUS_ADDR + 7'd1;
          P_HI: begin
            bus.o_sd_addr = STATUS_ADDR;
            if (w_status[ERR_BIT]) begin
              w_next = S_ERR;
            end
          end
          default: begin
            bus.o_sd_we   = 1'b1;
            bus.o_sd_addr = STATUS_ADDR;
            bus.o_sd_data = r_stat_lo;
            w_next        = S_DRAIN;
          end
        endcase
        if (w_timeout) begin
          w_next = S_ERR;
        end
      end
      S_DRAIN: begin
        bus.o_sd_fifo_rd = w_pop;
        if (w_xfer && (r_smp_cnt == 9'd255)) begin
          w_next = S_DONE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_poll     <= P_REQ;
      r_cmd_idx  <= 3'd0;
      r_stat_lo  <= 8'h00;
      r_tmo      <= '0;
      r_arg      <= 32'h0;
      r_pop_cnt  <= 10'd0;
      r_inflight <= 1'b0;
      r_half     <= 1'b0;
      r_lo_byte  <= 8'h00;
      r_buf[0]   <= 16'h0;
      r_buf[1]   <= 16'h0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_cnt      <= 2'd0;
      r_smp_cnt  <= 9'd0;
    end else if (w_start_ok) begin
      r_arg      <= w_arg;
      r_cmd_idx  <= 3'd0;
      r_poll     <= P_REQ;
      r_tmo      <= '0;
      r_pop_cnt  <= 10'd0;
      r_inflight <= 1'b0;
      r_half     <= 1'b0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_cnt      <= 2'd0;
      r_smp_cnt  <= 9'd0;
    end else begin
      case (r_state)
        S_CMD: r_cmd_idx <= r_cmd_idx + 3'd1;
        S_POLL: begin
          r_tmo <= r_tmo + 1'b1;
          case (r_poll)
            P_REQ: r_poll <= P_LO;
            P_LO: begin
              r_stat_lo <= bus.i_sd_data;
              r_poll    <= P_HI;
            end
            P_HI: r_poll <= (w_status[DONE_BIT] && !w_status[ERR_BIT]) ? P_CLR : P_LO;
            default: ;
          endcase
        end
        default: ;
      endcase

      r_inflight <= w_pop;
      if (w_pop) begin
        r_pop_cnt <= r_pop_cnt + 10'd1;
      end
      if (r_inflight) begin
        if (!r_half) begin
          r_lo_byte <= bus.i_sd_fifo_data;
          r_half    <= 1'b1;
        end else begin
          r_buf[r_wptr] <= {bus.i_sd_fifo_data, r_lo_byte};
          r_wptr        <= ~r_wptr;
          r_half        <= 1'b0;
        end
      end
      if (w_xfer) begin
        r_rptr    <= ~r_rptr;
        r_smp_cnt <= r_smp_cnt + 9'd1;
      end
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_xfer};

      if (r_state == S_ERR) begin
        r_cnt      <= 2'd0;
        r_half     <= 1'b0;
        r_inflight <= 1'b0;
        r_wptr     <= 1'b0;
        r_rptr     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sd_block_streamer.sv
// tb/tb_sd_block_streamer.sv - directed bench for sd_block_streamer with controller/FIFO stub
// Honours SD_BYTE_ADDR_EN when computing the expected CMD17 argument.
module tb_sd_block_streamer;
  localparam logic [6:0] STATUS_ADDR = 7'h30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sd_block_streamer_if bus();

  sd_block_streamer #(.TIMEOUT_CYCLES(100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  logic [7:0] brom [512];
  int         stat_mode;
  int         poll_cnt;
  int         rd_idx;
  logic [6:0] wr_a [$];
  logic [7:0] wr_d [$];

  // sdc_controller stand-in: registered reads, FIFO pop latency of one cycle.
  always @(posedge clk) begin
    if (bus.o_sd_we) begin
      wr_a.push_back(bus.o_sd_addr);
      wr_d.push_back(bus.o_sd_data);
      if (bus.o_sd_addr == 7'h00) begin
        rd_idx   <= 0;
        poll_cnt <= 0;
      end
      bus.i_sd_data <= 8'h00;
    end else if (bus.o_sd_addr == STATUS_ADDR) begin
      bus.i_sd_data <= (stat_mode == 0 && poll_cnt >= 2) ? 8'h01 : 8'h00;
    end else if (bus.o_sd_addr == STATUS_ADDR + 7'd1) begin
      bus.i_sd_data <= (stat_mode == 1) ? 8'h80 : 8'h00;
      poll_cnt      <= poll_cnt + 1;
    end else begin
      bus.i_sd_data <= 8'h00;
    end
    if (bus.o_sd_fifo_rd) begin
      bus.i_sd_fifo_data <= brom[rd_idx[8:0]];
      rd_idx             <= rd_idx + 1;
    end
  end

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_done, n_err, n_pops, t_poll, t_err, n_unstable, wbase;
  logic        busy_early, busy_after;
  logic [15:0] smp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_arg(input logic [31:0] baddr);
`ifdef SD_BYTE_ADDR_EN
    return {baddr[22:0], 9'b0};
`else
    return baddr;
`endif
  endfunction

  task automatic run_op(input logic [31:0] baddr, input int pct, input int rst_after, input int budget);
    bit          finished = 0;
    int          tail = 0;
    bit          hold = 0;
    logic [15:0] held = '0;
    n_done = 0; n_err = 0; n_pops = 0; t_poll = -1; t_err = -1; n_unstable = 0;
    smp_q.delete();
    wbase = wr_a.size();
    @(negedge clk);
    bus.i_block_addr = baddr;
    bus.i_start      = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      bus.i_start     = 1'b0;
      bus.i_smp_ready = ($urandom_range(0, 99) < pct);
      #1;
      if (c == 0) busy_early = bus.o_busy;
      if (hold && (!bus.o_smp_valid || bus.o_smp_data !== held)) n_unstable++;
      hold = bus.o_smp_valid && !bus.i_smp_ready;
      held = bus.o_smp_data;
      if (bus.o_smp_valid && bus.i_smp_ready) smp_q.push_back(bus.o_smp_data);
      if (bus.o_sd_fifo_rd) n_pops++;
      if (bus.o_done) n_done++;
      if (bus.o_error) begin
        n_err++;
        t_err = c;
      end
      if (t_poll < 0 && bus.o_busy && !bus.o_sd_we && bus.o_sd_addr == STATUS_ADDR) t_poll = c;
      if (rst_after > 0 && smp_q.size() == rst_after) begin
        rst = 1'b1;
        #1;
        check("rst_mid_ctl", {bus.o_busy, bus.o_done, bus.o_error, bus.o_sd_we, bus.o_sd_fifo_rd,
                              bus.o_smp_valid, bus.o_sd_addr, bus.o_sd_data}, 32'h0);
        check("rst_mid_smp", {16'h0, bus.o_smp_data}, 32'h0);
        break;
      end
      if (finished) begin
        tail++;
        if (tail == 3) break;
      end else if (bus.o_done || bus.o_error) begin
        finished = 1;
      end
    end
    busy_after = bus.o_busy;
  endtask

  task automatic check_samples(input string tag);
    int bad = 0;
    check({tag, "_count"}, smp_q.size(), 256);
    for (int k = 0; k < smp_q.size() && k < 256; k++) begin
      if (smp_q[k] !== {brom[2*k+1], brom[2*k]}) bad++;
    end
    check({tag, "_data"}, bad, 0);
    check({tag, "_unstable"}, n_unstable, 0);
  endtask

  task automatic check_trace(input logic [31:0] baddr, input int n_wr);
    logic [6:0]  ea [8];
    logic [7:0]  ed [8];
    logic [31:0] a;
    a  = exp_arg(baddr);
    ea = '{7'h44, 7'h45, 7'h05, 7'h04, 7'h03, 7'h02, 7'h01, 7'h00};
    ed = '{8'hFF, 8'h01, 8'h11, 8'h3D, a[31:24], a[23:16], a[15:8], a[7:0]};
    check("wr_count", wr_a.size() - wbase, n_wr);
    if (wr_a.size() - wbase >= 8) begin
      for (int i = 0; i < 8; i++) begin
        check($sformatf("wr%0d", i), {17'h0, wr_a[wbase+i], wr_d[wbase+i]}, {17'h0, ea[i], ed[i]});
      end
    end
    if (n_wr == 9 && wr_a.size() - wbase >= 9) begin
      check("wr_status_clr", {17'h0, wr_a[wbase+8], wr_d[wbase+8]}, {17'h0, STATUS_ADDR, 8'h01});
    end
  endtask

  initial begin
    logic [31:0] a3;
    bus.i_start      = 1'b0;
    bus.i_block_addr = 32'h0;
    bus.i_smp_ready  = 1'b0;
    stat_mode        = 0;
    for (int i = 0; i < 512; i++) brom[i] = 8'((i * 29 + (i >> 5) + 3) & 255);

    repeat (3) @(negedge clk);
    check("reset_ctl", {bus.o_busy, bus.o_done, bus.o_error, bus.o_sd_we, bus.o_sd_fifo_rd,
                        bus.o_smp_valid, bus.o_sd_addr, bus.o_sd_data}, 32'h0);
    check("reset_smp", {16'h0, bus.o_smp_data}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Full block, downstream always ready
    run_op(32'h0, 100, 0, 3000);
    check("t1_busy_early", busy_early, 1);
    check_trace(32'h0, 9);
    check_samples("t1");
    check("t1_done", n_done, 1);
    check("t1_err", n_err, 0);
    check("t1_pops", n_pops, 512);
    check("t1_busy_after", busy_after, 0);

    // Back-pressure at ~30% ready
    run_op(32'h0, 30, 0, 6000);
    check_samples("t2");
    check("t2_done", n_done, 1);
    check("t2_pops", n_pops, 512);
    check("t2_busy_after", busy_after, 0);

    // Argument mapping for block 3
    run_op(32'h3, 100, 0, 3000);
    a3 = exp_arg(32'h3);
    check_trace(32'h3, 9);
    check("t3_reg01", (wr_a.size() - wbase >= 8) ? {24'h0, wr_d[wbase+6]} : 32'hFFFF_FFFF, {24'h0, a3[15:8]});
    check("t3_reg00", (wr_a.size() - wbase >= 8) ? {24'h0, wr_d[wbase+7]} : 32'hFFFF_FFFF, {24'h0, a3[7:0]});
    check("t3_done", n_done, 1);

    // Error bit on first poll
    stat_mode = 1;
    run_op(32'h5, 100, 0, 400);
    check_trace(32'h5, 8);
    check("t4_err", n_err, 1);
    check("t4_done", n_done, 0);
    check("t4_samples", smp_q.size(), 0);
    check("t4_pops", n_pops, 0);
    check("t4_busy_after", busy_after, 0);

    // Status never completes: timeout after 100 poll cycles
    stat_mode = 2;
    run_op(32'h0, 100, 0, 400);
    check("t5_err", n_err, 1);
    check("t5_latency", (t_poll >= 0 && t_err - t_poll >= 98 && t_err - t_poll <= 102), 1);
    check("t5_pops", n_pops, 0);
    check("t5_busy_after", busy_after, 0);

    // Reset mid-drain, then a clean read
    stat_mode = 0;
    run_op(32'h0, 100, 100, 3000);
    check("t6_no_done", n_done, 0);
    check("t6_no_err", n_err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(32'h0, 100, 0, 3000);
    check_samples("t6");
    check("t6_done", n_done, 1);
    check("t6_pops", n_pops, 512);
    check("t6_busy_after", busy_after, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
